rotary_digit_editor: RTL
========================

# rotary_digit_editor

Parametrised rotary-encoder edit controller for the alarm-clock time display. Converts qualified encoder steps (A-channel pulse plus debounced B level) and a mode-toggle pulse into digit-select movement and per-digit increment/decrement strobes for `NUM_DIGITS` display digits. It drives the display blink logic, and adds an inactivity timeout that ends an edit session automatically.

## Interface
- `NUM_DIGITS`, 6: number of editable digits; index 0 is the least-significant (seconds units).
- `SEL_W`, 4: width of `o_Blink_Segment_Num`.
- `SEL_BASE`, 2: display segment number that corresponds to digit index 0.
- `TIMEOUT_CYCLES`, 50_000_000: idle cycles before auto-exit (used only with `ENCODER_TIMEOUT_EN`); must be ≥ 2.
- `TIMEOUT_W`, 26: counter width; must satisfy 2^`TIMEOUT_W` > `TIMEOUT_CYCLES`.

Ports:
- `i_Clk` in 1: system clock; all logic is rising-edge.
- `i_Reset_n` in 1: reset, synchronous, active-low.
- `i_Encoder_Enable` in 1: level; edit mode is permitted while high.
- `i_Encoder_Change_Mode` in 1: one-cycle pulse that toggles between SELECT and EDIT.
- `i_Encoder_A_Pulse` in 1: one-cycle pulse, one encoder detent.
- `i_Encoder_B_Debounced` in 1: direction level, sampled in the same cycle as the A pulse.
- `o_Digit_Inc` out `NUM_DIGITS`: one-hot one-cycle increment strobes.
- `o_Digit_Dec` out `NUM_DIGITS`: one-hot one-cycle decrement strobes.
- `o_Blink_Enable` out 1: high in SELECT or EDIT.
- `o_Blink_Segment_Num` out `SEL_W`: `SEL_BASE` + selected index.
- `o_Timeout` out 1: one-cycle pulse when the session auto-exits.

## Operation
- States: OFF, SELECT, EDIT. The state is registered.
- OFF → SELECT: `i_Encoder_Enable`=1 and lockout clear.
- SELECT ↔ EDIT: on `i_Encoder_Change_Mode`=1.
- Any state → OFF: `i_Encoder_Enable`=0, which has priority over everything else.
- SELECT/EDIT → OFF: on timeout, which sets the lockout flag.
- Lockout clears only while `i_Encoder_Enable`=0. This forces a disable/re-enable cycle after a timeout.
- Step is defined as `i_Encoder_A_Pulse`=1. Dir 0 is `i_Encoder_B_Debounced`=0; dir 1 is `i_Encoder_B_Debounced`=1.
- SELECT, step:
  - dir 0: index +1, wrapping from `NUM_DIGITS`-1 to 0.
  - dir 1: index −1, wrapping from 0 to `NUM_DIGITS`-1.
- EDIT, step:
  - dir 0: `o_Digit_Dec[index]`=1.
  - dir 1: `o_Digit_Inc[index]`=1.
  - At most one strobe bit is high in any cycle.
- Steps in OFF are ignored.
- Step and mode pulse in the same cycle: the step is acted on according to the current (pre-transition) state, and the state toggles at the same edge.
- The selected index is retained across OFF. Only reset returns it to 0.

## Timing
- Reset (`i_Reset_n`=0 at an edge) forces:
  - state OFF, index 0, lockout 0, timeout counter 0;
  - `o_Digit_Inc`/`o_Digit_Dec`=0, `o_Timeout`=0, `o_Blink_Enable`=0, `o_Blink_Segment_Num`=`SEL_BASE`.
- Reset mid-session aborts the session, and no strobe is emitted for a step in the reset cycle.
- Strobes, index and `o_Timeout` are registered. A step sampled at edge n produces its strobe or new index in cycle n+1.
- `o_Blink_Enable` is decoded from the state register, so it is valid in the cycle after the triggering input.
- Strobes last exactly one cycle. Back-to-back steps produce back-to-back strobes.
- Timeout counter behaviour:
  - cleared in OFF and on any step or mode pulse;
  - otherwise increments in SELECT/EDIT;
  - when it reaches `TIMEOUT_CYCLES`-1, the next edge moves the state to OFF and pulses `o_Timeout`.
  - A step in that same cycle wins: it is acted on and the counter clears.

## Configuration
- `ENCODER_TIMEOUT_EN` defined: the timeout counter, lockout flag and `o_Timeout` behave as specified above.
- Not defined: no counter or lockout; sessions end only on enable low or reset; `o_Timeout` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then enable with no pulses: next cycle `o_Blink_Enable`=1, `o_Blink_Segment_Num`=2, all strobes 0.
- SELECT, 6 steps with dir 0 (`NUM_DIGITS`=6): segment sequence 3,4,5,6,7,2. One further step with dir 1: segment 7.
- Mode pulse, then index 3 with steps dir 1 then dir 0: `o_Digit_Inc`=6'b001000 for one cycle, then `o_Digit_Dec`=6'b001000 for one cycle.
- Step and mode pulse in the same cycle while in SELECT: index moves, state becomes EDIT, no strobe. Same case while in EDIT: one strobe, state becomes SELECT.
- With `ENCODER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, idle in EDIT:
  - `o_Timeout` pulses once, `o_Blink_Enable` falls, and the block stays OFF while enable is held high;
  - enable low for 1 cycle then high: SELECT re-entered, previous index preserved.
- Assert `i_Reset_n`=0 during EDIT together with a step: no strobe, all outputs at their reset values on the next cycle.

Source files
------------

// File: rtl/rotary_digit_editor_if.sv
// Encoder-side bundle for rotary_digit_editor.
// The master drives the qualified encoder events and observes the edit
// strobes and blink controls. The slave is the editor itself.
interface rotary_digit_editor_if #(
    parameter int NUM_DIGITS = 6,
    parameter int SEL_W      = 4
);
    logic                  i_Encoder_Enable;
    logic                  i_Encoder_Change_Mode;
    logic                  i_Encoder_A_Pulse;
    logic                  i_Encoder_B_Debounced;
    logic [NUM_DIGITS-1:0] o_Digit_Inc;
    logic [NUM_DIGITS-1:0] o_Digit_Dec;
    logic                  o_Blink_Enable;
    logic [SEL_W-1:0]      o_Blink_Segment_Num;
    logic                  o_Timeout;

    modport master (
        output i_Encoder_Enable,
        output i_Encoder_Change_Mode,
        output i_Encoder_A_Pulse,
        output i_Encoder_B_Debounced,
        input  o_Digit_Inc,
        input  o_Digit_Dec,
        input  o_Blink_Enable,
        input  o_Blink_Segment_Num,
        input  o_Timeout
    );

    modport slave (
        input  i_Encoder_Enable,
        input  i_Encoder_Change_Mode,
        input  i_Encoder_A_Pulse,
        input  i_Encoder_B_Debounced,
        output o_Digit_Inc,
        output o_Digit_Dec,
        output o_Blink_Enable,
        output o_Blink_Segment_Num,
        output o_Timeout
    );
endinterface

// File: rtl/rotary_digit_editor.sv
// Rotary-encoder edit controller for the alarm-clock time display.
// In SELECT, encoder detents move the selected digit. In EDIT, detents
// produce one-cycle increment or decrement strobes for the selected digit.
// The optional inactivity timeout is enabled by defining ENCODER_TIMEOUT_EN.
// With the macro undefined, there is no counter and no lockout, and
// o_Timeout is tied low.
module rotary_digit_editor #(
    parameter int NUM_DIGITS     = 6,
    parameter int SEL_W          = 4,
    parameter int SEL_BASE       = 2,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TIMEOUT_W      = 26
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset_n,
    rotary_digit_editor_if.slave    bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT_LSB = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SELECT,
        ST_EDIT
    } state_t;

    state_t                state_q;
    logic [IDX_W-1:0]      index_q;
    logic [NUM_DIGITS-1:0] inc_q;
    logic [NUM_DIGITS-1:0] dec_q;

    logic                  step;
    logic                  dir_up;
    logic                  mode_pulse;
    logic [IDX_W-1:0]      index_up;
    logic [IDX_W-1:0]      index_down;
    logic [NUM_DIGITS-1:0] index_onehot;

    // A misconfigured timeout shows up as this block in the elaborated hierarchy
    if (TIMEOUT_CYCLES < 2 || (TIMEOUT_W < 31 && (1 << TIMEOUT_W) <= TIMEOUT_CYCLES)) begin : g_bad_timeout_cfg
    end

    assign step       = bus.i_Encoder_A_Pulse;
    assign dir_up     = bus.i_Encoder_B_Debounced;
    assign mode_pulse = bus.i_Encoder_Change_Mode;

    assign index_up     = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
    assign index_down   = (index_q == '0) ? IDX_LAST : index_q - 1'b1;
    assign index_onehot = ONE_HOT_LSB << index_q;

`ifdef ENCODER_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic                 lockout_q;
    logic [TIMEOUT_W-1:0] count_q;
    logic                 timeout_q;
`endif

    // Session FSM with registered index, strobes and timeout pulse.
    // The step is handled using the state before any mode toggle at the same edge.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            state_q   <= ST_OFF;
            index_q   <= '0;
            inc_q     <= '0;
            dec_q     <= '0;
`ifdef ENCODER_TIMEOUT_EN
            lockout_q <= 1'b0;
            count_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            inc_q <= '0;
            dec_q <= '0;
`ifdef ENCODER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            if (!bus.i_Encoder_Enable) begin
                state_q <= ST_OFF;
`ifdef ENCODER_TIMEOUT_EN
                lockout_q <= 1'b0;
                count_q   <= '0;
`endif
            end else begin
                case (state_q)
                    ST_OFF: begin
`ifdef ENCODER_TIMEOUT_EN
                        count_q <= '0;
                        if (!lockout_q) begin
                            state_q <= ST_SELECT;
                        end
`else
                        state_q <= ST_SELECT;
`endif
                    end
                    ST_SELECT, ST_EDIT: begin
                        if (step) begin
                            if (state_q == ST_SELECT) begin
                                index_q <= dir_up ? index_down : index_up;
                            end else if (dir_up) begin
                                inc_q <= index_onehot;
                            end else begin
                                dec_q <= index_onehot;
                            end
                        end
                        if (mode_pulse) begin
                            state_q <= (state_q == ST_SELECT) ? ST_EDIT : ST_SELECT;
                        end
`ifdef ENCODER_TIMEOUT_EN
                        if (step || mode_pulse) begin
                            count_q <= '0;
                        end else if (count_q == TIMEOUT_LAST) begin
                            state_q   <= ST_OFF;
                            timeout_q <= 1'b1;
                            lockout_q <= 1'b1;
                            count_q   <= '0;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
`endif
                    end
                    default: begin
                        state_q <= ST_OFF;
                    end
                endcase
            end
        end
    end

    assign bus.o_Digit_Inc         = inc_q;
    assign bus.o_Digit_Dec         = dec_q;
    assign bus.o_Blink_Enable      = (state_q != ST_OFF);
    assign bus.o_Blink_Segment_Num = SEL_W'(SEL_BASE) + SEL_W'(index_q);
`ifdef ENCODER_TIMEOUT_EN
    assign bus.o_Timeout = timeout_q;
`else
    assign bus.o_Timeout = 1'b0;
`endif

endmodule
